// File: rtl/itrx_aib_phy_latn_bank_if.sv
// rtl/itrx_aib_phy_latn_bank_if.sv - update handshake and channel data bundle for the hold bank
//
// Purpose: groups the hold bank's control, data and handshake signals.
// Ports (as seen by the slave / bank):
//   mode     in   1 = transparent, 0 = hold
//   din      in   NCH*W channel data, channel i at [i*W +: W]
//   ch_mask  in   channels to update, sampled with the request
//   upd_req  in   4-phase update request
//   upd_ack  out  update acknowledge
//   busy     out  update in progress
//   qout     out  held channel data
//   qvld     out  channel written since reset
interface itrx_aib_phy_latn_bank_if #(
    parameter int W   = 8,
    parameter int NCH = 4
);
    logic               mode;
    logic [NCH*W-1:0]   din;
    logic [NCH-1:0]     ch_mask;
    logic               upd_req;
    logic               upd_ack;
    logic               busy;
    logic [NCH*W-1:0]   qout;
    logic [NCH-1:0]     qvld;

    modport master (
        output mode, din, ch_mask, upd_req,
        input  upd_ack, busy, qout, qvld
    );

    modport slave (
        input  mode, din, ch_mask, upd_req,
        output upd_ack, busy, qout, qvld
    );
endinterface

// File: rtl/itrx_aib_phy_latn_bank.sv
// rtl/itrx_aib_phy_latn_bank.sv - multi-channel hold bank with atomic masked update
//
// Purpose: holds AIB PHY static controls. In transparent mode qout follows
// din with one cycle of latency. In hold mode qout changes only through a
// masked update, committed on a single edge HOLD_CYC cycles after capture.
// Ports:
//   clk   in  clock
//   rstn  in  synchronous active-low reset
//   bus   slave modport of itrx_aib_phy_latn_bank_if
module itrx_aib_phy_latn_bank #(
    parameter int W        = 8,
    parameter int NCH      = 4,
    parameter int HOLD_CYC = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    itrx_aib_phy_latn_bank_if.slave   bus
);
    localparam int CW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (HOLD_CYC > 0) ? CW'(HOLD_CYC - 1) : '0;

    typedef enum logic [1:0] {IDLE, SETTLE, ACK} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [NCH*W-1:0]   shadow, shadow_nxt;
    logic [NCH-1:0]     smask, smask_nxt;
    logic [NCH*W-1:0]   qout_r, qout_nxt;
    logic [NCH-1:0]     qvld_r, qvld_nxt;
    logic               ack_r, ack_nxt;
    logic               busy_r, busy_nxt;

    // Commit source: the shadow after settling, or din/ch_mask directly when
    // there is no settle window.
    logic               commit;
    logic [NCH*W-1:0]   com_data;
    logic [NCH-1:0]     com_mask;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= '0;
            smask  <= '0;
            qout_r <= '0;
            qvld_r <= '0;
            ack_r  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            shadow <= shadow_nxt;
            smask  <= smask_nxt;
            qout_r <= qout_nxt;
            qvld_r <= qvld_nxt;
            ack_r  <= ack_nxt;
            busy_r <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        smask_nxt  = smask;
        qout_nxt   = qout_r;
        qvld_nxt   = qvld_r;
        ack_nxt    = ack_r;
        commit     = 1'b0;
        com_data   = shadow;
        com_mask   = smask;

        case (state)
            IDLE: begin
                // A request outranks transparent tracking on the same edge.
                if (bus.upd_req) begin
                    shadow_nxt = bus.din;
                    smask_nxt  = bus.ch_mask;
                    if (HOLD_CYC == 0) begin
                        commit    = 1'b1;
                        com_data  = bus.din;
                        com_mask  = bus.ch_mask;
                        state_nxt = ACK;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = SETTLE;
                    end
                end else if (bus.mode) begin
                    qout_nxt = bus.din;
                    qvld_nxt = '1;
                end
            end
            SETTLE: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    commit    = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!bus.upd_req) begin
                    ack_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (commit) begin
            ack_nxt = 1'b1;
            for (int i = 0; i < NCH; i++) begin
                if (com_mask[i]) begin
                    qout_nxt[i*W +: W] = com_data[i*W +: W];
                    qvld_nxt[i]        = 1'b1;
                end
            end
        end

        // With no settle window the update never reports busy, even while
        // waiting in ACK for the request to drop.
        busy_nxt = (HOLD_CYC > 0) && (state_nxt != IDLE);
    end

    assign bus.qout    = qout_r;
    assign bus.qvld    = qvld_r;
    assign bus.upd_ack = ack_r;
    assign bus.busy    = busy_r;
endmodule

// File: tb/tb_itrx_aib_phy_latn_bank.sv
// tb/tb_itrx_aib_phy_latn_bank.sv - self-checking bench for itrx_aib_phy_latn_bank
module tb_itrx_aib_phy_latn_bank;
    localparam int W   = 8;
    localparam int NCH = 4;
    localparam int HC  = 4;
    localparam int DW  = NCH * W;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    itrx_aib_phy_latn_bank_if #(.W(W), .NCH(NCH)) if4 ();
    itrx_aib_phy_latn_bank_if #(.W(W), .NCH(NCH)) if0 ();

    itrx_aib_phy_latn_bank #(.W(W), .NCH(NCH), .HOLD_CYC(HC)) dut4 (
        .clk(clk), .rstn(rstn), .bus(if4.slave));
    itrx_aib_phy_latn_bank #(.W(W), .NCH(NCH), .HOLD_CYC(0)) dut0 (
        .clk(clk), .rstn(rstn), .bus(if0.slave));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: what each bank should be holding.
    logic [DW-1:0]  m_q,  m0_q;
    logic [NCH-1:0] m_v,  m0_v;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] q,
                                            input logic [DW-1:0] d,
                                            input logic [NCH-1:0] m);
        logic [DW-1:0] r;
        r = q;
        for (int i = 0; i < NCH; i++)
            if (m[i]) r[i*W +: W] = d[i*W +: W];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_q = '0; m_v = '0; m0_q = '0; m0_v = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        if4.mode = 1'b1; if4.din = '1; if4.upd_req = 1'b0; if4.ch_mask = '0;
        if0.mode = 1'b0; if0.din = '0; if0.upd_req = 1'b0; if0.ch_mask = '0;
        repeat (3) tick();
        model_reset();
        n_cmp++; if (if4.qout !== '0) begin n_bad++; $display("FAIL rst_qout got %h exp %h", if4.qout, 32'h0); end
        n_cmp++; if (if4.qvld !== '0) begin n_bad++; $display("FAIL rst_qvld got %h exp 0", if4.qvld); end
        n_cmp++; if (if4.upd_ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack got %b exp 0", if4.upd_ack); end
        n_cmp++; if (if4.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b exp 0", if4.busy); end
        rstn = 1'b1;
        tick();
        m_q = '1; m_v = '1;
        n_cmp++; if (if4.qout !== m_q) begin n_bad++; $display("FAIL rst_first_qout got %h exp %h", if4.qout, m_q); end
        n_cmp++; if (if4.qvld !== 4'hF) begin n_bad++; $display("FAIL rst_first_qvld got %h exp F", if4.qvld); end
    endtask

    task automatic test_transparent();
        logic [DW-1:0] pat [$];
        pat.push_back(32'h01234567);
        pat.push_back(32'h89ABCDEF);
        for (int i = 0; i < 6; i++) pat.push_back($urandom);
        if4.mode = 1'b1;
        foreach (pat[i]) begin
            if4.din = pat[i];
            tick();
            m_q = pat[i]; m_v = '1;
            n_cmp++; if (if4.qout !== m_q) begin n_bad++; $display("FAIL transp_qout[%0d] got %h exp %h", i, if4.qout, m_q); end
            n_cmp++; if (if4.qvld !== m_v) begin n_bad++; $display("FAIL transp_qvld[%0d] got %h exp %h", i, if4.qvld, m_v); end
        end
    endtask

    // One full handshake on the HOLD_CYC=4 bank. Inputs are scrambled during
    // settle; with flip_mode the bank is asked to go transparent mid-update.
    task automatic test_update(input logic [DW-1:0] data, input logic [NCH-1:0] mask,
                               input bit flip_mode);
        int extra;
        if4.upd_req = 1'b1; if4.din = data; if4.ch_mask = mask;
        tick();
        n_cmp++; if (if4.busy !== 1'b1) begin n_bad++; $display("FAIL upd_busy_e0 got %b exp 1", if4.busy); end
        n_cmp++; if (if4.upd_ack !== 1'b0) begin n_bad++; $display("FAIL upd_ack_e0 got %b exp 0", if4.upd_ack); end
        n_cmp++; if (if4.qout !== m_q) begin n_bad++; $display("FAIL upd_qout_e0 got %h exp %h", if4.qout, m_q); end
        for (int k = 1; k <= HC; k++) begin
            if4.din = (k == 1) ? '0 : DW'($urandom);
            if4.ch_mask = NCH'($urandom);
            if (flip_mode) if4.mode = 1'b1;
            tick();
            if (k < HC) begin
                n_cmp++; if (if4.qout !== m_q) begin n_bad++; $display("FAIL settle_qout[%0d] got %h exp %h", k, if4.qout, m_q); end
                n_cmp++; if (if4.upd_ack !== 1'b0) begin n_bad++; $display("FAIL settle_ack[%0d] got %b exp 0", k, if4.upd_ack); end
                n_cmp++; if (if4.busy !== 1'b1) begin n_bad++; $display("FAIL settle_busy[%0d] got %b exp 1", k, if4.busy); end
            end
        end
        m_q = merge(m_q, data, mask);
        m_v = m_v | mask;
        n_cmp++; if (if4.qout !== m_q) begin n_bad++; $display("FAIL commit_qout got %h exp %h", if4.qout, m_q); end
        n_cmp++; if (if4.qvld !== m_v) begin n_bad++; $display("FAIL commit_qvld got %h exp %h", if4.qvld, m_v); end
        n_cmp++; if (if4.upd_ack !== 1'b1) begin n_bad++; $display("FAIL commit_ack got %b exp 1", if4.upd_ack); end
        n_cmp++; if (if4.busy !== 1'b1) begin n_bad++; $display("FAIL commit_busy got %b exp 1", if4.busy); end
        extra = $urandom_range(0, 2);
        for (int k = 0; k < extra; k++) begin
            if4.din = $urandom;
            tick();
            n_cmp++; if (if4.upd_ack !== 1'b1 || if4.qout !== m_q) begin n_bad++; $display("FAIL ack_hold ack %b qout %h exp 1 %h", if4.upd_ack, if4.qout, m_q); end
        end
        if4.upd_req = 1'b0; if4.din = $urandom;
        tick();
        n_cmp++; if (if4.upd_ack !== 1'b0) begin n_bad++; $display("FAIL release_ack got %b exp 0", if4.upd_ack); end
        n_cmp++; if (if4.busy !== 1'b0) begin n_bad++; $display("FAIL release_busy got %b exp 0", if4.busy); end
        n_cmp++; if (if4.qout !== m_q) begin n_bad++; $display("FAIL release_qout got %h exp %h", if4.qout, m_q); end
        if (if4.mode) begin
            if4.din = $urandom;
            tick();
            m_q = if4.din; m_v = '1;
            n_cmp++; if (if4.qout !== m_q) begin n_bad++; $display("FAIL post_ack_track got %h exp %h", if4.qout, m_q); end
        end
    endtask

    task automatic test_masked_update();
        if4.mode = 1'b0; rstn = 1'b0;
        tick();
        rstn = 1'b1; model_reset();
        tick();
        test_update(32'hA5A5A5A5, 4'b0101, 1'b0);
        n_cmp++; if (if4.qout !== 32'h00A500A5) begin n_bad++; $display("FAIL masked_qout got %h exp 00a500a5", if4.qout); end
        n_cmp++; if (if4.qvld !== 4'b0101) begin n_bad++; $display("FAIL masked_qvld got %b exp 0101", if4.qvld); end
    endtask

    task automatic test_mode_toggle();
        if4.mode = 1'b0;
        test_update($urandom, NCH'($urandom), 1'b1);
    endtask

    task automatic test_mask_zero();
        logic [DW-1:0]  q0;
        logic [NCH-1:0] v0;
        q0 = m_q; v0 = m_v;
        if4.mode = 1'b0;
        test_update($urandom, '0, 1'b0);
        n_cmp++; if (if4.qout !== q0 || if4.qvld !== v0) begin n_bad++; $display("FAIL mask0 qout %h qvld %h exp %h %h", if4.qout, if4.qvld, q0, v0); end
    endtask

    task automatic test_reset_mid();
        if4.mode = 1'b0; if4.upd_req = 1'b1; if4.din = $urandom; if4.ch_mask = '1;
        tick();
        tick();
        rstn = 1'b0; if4.upd_req = 1'b0;
        tick();
        model_reset();
        n_cmp++; if (if4.qout !== '0 || if4.qvld !== '0) begin n_bad++; $display("FAIL midrst_q qout %h qvld %h exp 0 0", if4.qout, if4.qvld); end
        n_cmp++; if (if4.busy !== 1'b0 || if4.upd_ack !== 1'b0) begin n_bad++; $display("FAIL midrst_hs busy %b ack %b exp 0 0", if4.busy, if4.upd_ack); end
        rstn = 1'b1;
        tick();
        n_cmp++; if (if4.qout !== '0) begin n_bad++; $display("FAIL midrst_idle got %h exp 0", if4.qout); end
        test_update($urandom, NCH'($urandom), 1'b0);
    endtask

    task automatic test_random_updates();
        for (int n = 0; n < 5; n++) begin
            if4.mode = 1'($urandom); if4.din = $urandom;
            tick();
            if (if4.mode) begin m_q = if4.din; m_v = '1; end
            n_cmp++; if (if4.qout !== m_q) begin n_bad++; $display("FAIL rnd_idle[%0d] got %h exp %h", n, if4.qout, m_q); end
            if4.mode = 1'b0;
            test_update($urandom, NCH'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_hold0();
        logic [DW-1:0]  d;
        logic [NCH-1:0] m;
        for (int n = 0; n < 3; n++) begin
            d = $urandom; m = NCH'($urandom);
            if (n == 0) m = '0;
            if0.mode = 1'b0; if0.upd_req = 1'b1; if0.din = d; if0.ch_mask = m;
            tick();
            m0_q = merge(m0_q, d, m); m0_v = m0_v | m;
            n_cmp++; if (if0.qout !== m0_q || if0.qvld !== m0_v) begin n_bad++; $display("FAIL h0_commit qout %h qvld %h exp %h %h", if0.qout, if0.qvld, m0_q, m0_v); end
            n_cmp++; if (if0.upd_ack !== 1'b1 || if0.busy !== 1'b0) begin n_bad++; $display("FAIL h0_ack ack %b busy %b exp 1 0", if0.upd_ack, if0.busy); end
            if0.din = $urandom;
            tick();
            n_cmp++; if (if0.upd_ack !== 1'b1 || if0.busy !== 1'b0 || if0.qout !== m0_q) begin n_bad++; $display("FAIL h0_hold ack %b busy %b qout %h exp 1 0 %h", if0.upd_ack, if0.busy, if0.qout, m0_q); end
            if0.upd_req = 1'b0;
            tick();
            n_cmp++; if (if0.upd_ack !== 1'b0 || if0.busy !== 1'b0) begin n_bad++; $display("FAIL h0_release ack %b busy %b exp 0 0", if0.upd_ack, if0.busy); end
        end
        if0.mode = 1'b1; if0.din = $urandom;
        tick();
        m0_q = if0.din; m0_v = '1;
        n_cmp++; if (if0.qout !== m0_q || if0.qvld !== m0_v) begin n_bad++; $display("FAIL h0_track qout %h qvld %h exp %h %h", if0.qout, if0.qvld, m0_q, m0_v); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_transparent();
        test_masked_update();
        test_mode_toggle();
        test_mask_zero();
        test_reset_mid();
        test_random_updates();
        test_hold0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/itrx_aib_phy_latn_bank.md
# itrx_aib_phy_latn_bank

Parametrised multi-channel hold bank for AIB PHY configuration and static-control signals. It is the clocked, multi-bit successor of the single-bit active-low latch cell. It provides:
- a transparent mode, where outputs track inputs with one cycle of latency;
- a hold mode, where outputs are frozen and change only through an atomic, masked update handshake.

After a settle window of HOLD_CYC cycles, all selected channels commit on the same clock edge. Software or config logic therefore cannot glitch analog-facing controls mid-update.

## Interface
- W, 8, data width per channel (≥1)
- NCH, 4, channel count (≥1)
- HOLD_CYC, 4, settle cycles between capture and commit (≥0)

- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- mode  input  1  1 = transparent, 0 = hold; sampled only in IDLE
- din  input  NCH*W  channel data; channel i at [i*W +: W]
- ch_mask  input  NCH  channels to update; sampled with the request
- upd_req  input  1  update request, 4-phase level handshake
- upd_ack  output  1  update acknowledge
- busy  output  1  update in progress (state ≠ IDLE)
- qout  output  NCH*W  held channel data
- qvld  output  NCH  channel i has been written since reset

## Operation
- Reset (rstn low at a clk edge) forces the following, regardless of state:
  - qout=0, qvld=0, upd_ack=0, busy=0;
  - shadow data and stored mask=0, counter=0, state=IDLE.
- FSM states are IDLE, SETTLE and ACK. busy, upd_ack and qout are all registered.
- IDLE, mode=1, upd_req=0: qout ← din for all channels; qvld ← all ones.
- IDLE, mode=0, upd_req=0: qout and qvld hold.
- IDLE, upd_req=1 (either mode): upd_req has priority over transparent tracking.
  - shadow ← din and smask ← ch_mask; qout is not changed this edge.
  - HOLD_CYC>0: state ← SETTLE, cnt ← 0.
  - HOLD_CYC=0: commit immediately (see ACK entry).
- SETTLE:
  - qout frozen; mode, din and ch_mask are ignored.
  - cnt increments each edge.
  - At the edge where cnt==HOLD_CYC-1: commit, then go to ACK.
- Commit/ACK entry:
  - for each i with smask[i]=1: qout[i] ← shadow[i], qvld[i] ← 1;
  - unmasked channels are untouched;
  - upd_ack ← 1.
- ACK:
  - qout frozen; upd_ack stays high until upd_req is sampled low.
  - At that edge: upd_ack ← 0, state ← IDLE.
- smask=0 completes the full handshake with no qout or qvld change.
- upd_req already high when the FSM returns to IDLE is impossible under the 4-phase protocol. upd_req must be low for ≥1 edge, and the FSM exits ACK only on low.
- upd_req rising while busy is meaningless; it is only observed in IDLE.
- mode changes while busy take effect on the first IDLE edge after ACK.
- Counter width is max(1, $clog2(HOLD_CYC+1)).

## Timing
- Transparent path: din at edge E, with upd_req=0, appears on qout after E (1-cycle latency).
- Update: upd_req is sampled high in IDLE at edge E0.
  - busy is high after E0.
  - qout commit and upd_ack rise together after edge E0+HOLD_CYC.
  - HOLD_CYC=0: both are visible after E0, with busy low throughout.
- Release: upd_req is sampled low at edge Er in ACK.
  - upd_ack and busy fall after Er.
  - IDLE processing, including transparent tracking, resumes at Er+1.
- Minimum full handshake is HOLD_CYC+2 edges.
- Capture data is from E0 only; din changes during SETTLE never reach qout.

## Test plan
- Reset: hold rstn low 3 cycles with din=all ones, mode=1 → qout=0, qvld=0, upd_ack=0, busy=0; first edge after release gives qout=din, qvld=4'hF.
- Transparent: mode=1, drive din=32'h01234567 then 32'h89ABCDEF on consecutive edges → qout follows with 1-cycle lag; qvld=4'hF.
- Masked update, HOLD_CYC=4: mode=0, qout=0, din=32'hA5A5A5A5, ch_mask=4'b0101, upd_req rises at E0; din changes to 0 at E0+1 → qout=32'h00A500A5 and upd_ack=1 after E0+4; qvld=4'b0101; ack falls one edge after req drops.
- Mode toggle mid-update: mode 0→1 during SETTLE → qout frozen until commit; transparent tracking restarts at first IDLE edge after ACK.
- Reset mid-update: rstn low during SETTLE → all outputs 0 next edge, state IDLE; a subsequent request completes normally.
- Edge cases: ch_mask=0 gives ack with no qout/qvld change. With HOLD_CYC=0 build, ack and qout update one edge after request and busy never asserts.
